// File: rtl/ten_eth_port_seek_pkg.sv
// Shared types and field positions for the 10G RX destination-lookup engine.
package ten_eth_pkg;

    typedef enum logic [1:0] {
        SEEK_LOCAL  = 2'd0,
        SEEK_UPLINK = 2'd1,
        SEEK_BUFFER = 2'd2,
        SEEK_DROP   = 2'd3
    } seek_flag_e;

    localparam int MAC_W       = 48;
    localparam int ID_W        = 4;
    localparam int PORT_CODE_W = 3;

    // dst_mac layout: [47:16] head, [15:11] must be zero, [10:8] tor, [7:0] port
    localparam int MAC_HEAD_LSB   = 16;
    localparam int MAC_TOR_HI_LSB = 11;
    localparam int MAC_TOR_LSB    = 8;
    localparam int MAC_PORT_LSB   = 0;

    localparam logic [31:0] DEF_MAC_HEAD = 32'h8DBC_5C4A;

    typedef struct packed {
        logic [PORT_CODE_W-1:0] outport;
        seek_flag_e             flag;
    } seek_res_t;

endpackage

// File: rtl/ten_eth_port_seek_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the port after the last winner.
module rr_arbiter
    import ten_eth_pkg::*;
#(
    parameter int  P_PORT_NUM = 4,
    localparam int IDX_W      = (P_PORT_NUM > 1) ? $clog2(P_PORT_NUM) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [P_PORT_NUM-1:0] i_req,
    output logic [P_PORT_NUM-1:0] o_gnt,
    output logic [IDX_W-1:0]      o_gnt_idx,
    output logic                  o_gnt_vld
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    int               cand;

    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_idx = '0;
        cand      = 0;
        for (int i = 0; i < P_PORT_NUM; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= P_PORT_NUM) begin
                cand = cand - P_PORT_NUM;
            end
            if (!o_gnt_vld && i_req[cand[IDX_W-1:0]]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = cand[IDX_W-1:0];
            end
        end
        o_gnt = o_gnt_vld ? (P_PORT_NUM'(1) << o_gnt_idx) : '0;

        ptr_d = ptr_q;
        if (o_gnt_vld) begin
            ptr_d = (o_gnt_idx == IDX_W'(P_PORT_NUM - 1)) ? '0 : o_gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ten_eth_port_seek.sv
// Shared destination-MAC lookup for the RX ports: capture, round-robin grant, decode.
module ten_eth_port_seek
    import ten_eth_pkg::*;
#(
    parameter int          P_PORT_NUM    = 4,
    parameter logic [31:0] P_MAC_HEAD    = DEF_MAC_HEAD,
    parameter logic [2:0]  P_MY_TOR_ID   = 3'd0,
    parameter int          P_DOWN_PORTS  = 2,
    parameter logic [2:0]  P_UPLINK_PORT = 3'd7
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [MAC_W*P_PORT_NUM-1:0] i_check_mac,
    input  logic [ID_W*P_PORT_NUM-1:0]  i_check_id,
    input  logic [P_PORT_NUM-1:0]       i_check_valid,
    input  logic [2:0]                  i_cur_connect_tor,
    input  logic                        i_connect_valid,
    output logic [PORT_CODE_W-1:0]      o_outport,
    output logic [1:0]                  o_seek_flag,
    output logic [ID_W-1:0]             o_check_id,
    output logic [P_PORT_NUM-1:0]       o_result_valid,
    output logic [P_PORT_NUM-1:0]       o_req_overrun
);

    localparam int IDX_W = (P_PORT_NUM > 1) ? $clog2(P_PORT_NUM) : 1;

    logic [MAC_W-1:0]       slot_mac_q [P_PORT_NUM];
    logic [MAC_W-1:0]       slot_mac_d [P_PORT_NUM];
    logic [ID_W-1:0]        slot_id_q  [P_PORT_NUM];
    logic [ID_W-1:0]        slot_id_d  [P_PORT_NUM];
    logic [P_PORT_NUM-1:0]  pending_q, pending_d;
    logic [P_PORT_NUM-1:0]  ovr_p1_q, ovr_p1_d;

    logic [P_PORT_NUM-1:0]  gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_vld;

    logic                   vld_p1_q, vld_p1_d;
    logic [MAC_W-1:0]       mac_p1_q, mac_p1_d;
    logic [ID_W-1:0]        id_p1_q, id_p1_d;
    logic [IDX_W-1:0]       port_p1_q, port_p1_d;

    seek_res_t              dec;
    logic [P_PORT_NUM-1:0]  result_valid_q, result_valid_d;
    logic [P_PORT_NUM-1:0]  overrun_q, overrun_d;
    logic [PORT_CODE_W-1:0] outport_q, outport_d;
    logic [1:0]             flag_q, flag_d;
    logic [ID_W-1:0]        id_q, id_d;

    function automatic seek_res_t seek_decode(
        input logic [MAC_W-1:0] mac,
        input logic [2:0]       cur_tor,
        input logic             conn_vld
    );
        logic [7:0] port_byte;
        logic [2:0] tor;
        seek_res_t  res;
        port_byte   = mac[MAC_TOR_LSB-1:MAC_PORT_LSB];
        tor         = mac[MAC_TOR_HI_LSB-1:MAC_TOR_LSB];
        res.outport = '0;
        res.flag    = SEEK_DROP;
        if (mac[MAC_W-1:MAC_HEAD_LSB] == P_MAC_HEAD &&
            mac[MAC_HEAD_LSB-1:MAC_TOR_HI_LSB] == '0) begin
            if (tor == P_MY_TOR_ID) begin
                if (port_byte >= 8'd1 && port_byte <= 8'(P_DOWN_PORTS)) begin
                    res.flag    = SEEK_LOCAL;
                    res.outport = 3'(port_byte - 8'd1);
                end
            end else if (conn_vld && tor == cur_tor) begin
                res.flag    = SEEK_UPLINK;
                res.outport = P_UPLINK_PORT;
            end else begin
                res.flag    = SEEK_BUFFER;
                res.outport = tor;
            end
        end
        return res;
    endfunction

    rr_arbiter #(.P_PORT_NUM(P_PORT_NUM)) u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (pending_q),
        .o_gnt     (gnt),
        .o_gnt_idx (gnt_idx),
        .o_gnt_vld (gnt_vld)
    );

    always_comb begin
        // A grant and a fresh request on the same port: the new one is queued, no overrun.
        pending_d = (pending_q & ~gnt) | i_check_valid;
        ovr_p1_d  = i_check_valid & pending_q & ~gnt;
        for (int p = 0; p < P_PORT_NUM; p++) begin
            slot_mac_d[p] = slot_mac_q[p];
            slot_id_d[p]  = slot_id_q[p];
            if (i_check_valid[p]) begin
                slot_mac_d[p] = i_check_mac[p*MAC_W +: MAC_W];
                slot_id_d[p]  = i_check_id[p*ID_W +: ID_W];
            end
        end

        // Stage 1: granted slot.
        vld_p1_d  = gnt_vld;
        mac_p1_d  = mac_p1_q;
        id_p1_d   = id_p1_q;
        port_p1_d = port_p1_q;
        if (gnt_vld) begin
            mac_p1_d  = slot_mac_q[gnt_idx];
            id_p1_d   = slot_id_q[gnt_idx];
            port_p1_d = gnt_idx;
        end

        // Stage 2: decode against the uplink state seen at this edge.
        dec            = seek_decode(mac_p1_q, i_cur_connect_tor, i_connect_valid);
        result_valid_d = vld_p1_q ? (P_PORT_NUM'(1) << port_p1_q) : '0;
        overrun_d      = ovr_p1_q;
        outport_d      = outport_q;
        flag_d         = flag_q;
        id_d           = id_q;
        if (vld_p1_q) begin
            outport_d = dec.outport;
            flag_d    = dec.flag;
            id_d      = id_p1_q;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int p = 0; p < P_PORT_NUM; p++) begin
            slot_mac_q[p] <= slot_mac_d[p];
            slot_id_q[p]  <= slot_id_d[p];
        end
        mac_p1_q  <= mac_p1_d;
        id_p1_q   <= id_p1_d;
        port_p1_q <= port_p1_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q      <= '0;
            ovr_p1_q       <= '0;
            vld_p1_q       <= 1'b0;
            result_valid_q <= '0;
            overrun_q      <= '0;
            outport_q      <= '0;
            flag_q         <= '0;
            id_q           <= '0;
        end else begin
            pending_q      <= pending_d;
            ovr_p1_q       <= ovr_p1_d;
            vld_p1_q       <= vld_p1_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
            outport_q      <= outport_d;
            flag_q         <= flag_d;
            id_q           <= id_d;
        end
    end

    assign o_outport      = outport_q;
    assign o_seek_flag    = flag_q;
    assign o_check_id     = id_q;
    assign o_result_valid = result_valid_q;
    assign o_req_overrun  = overrun_q;

endmodule

// File: doc/ten_eth_port_seek.md
Name: ten_eth_port_seek

Overview:
- Shared destination-lookup engine serving the 10G Ethernet RX ports of one ToR.
- Each RX port presents the destination MAC of a packet it is holding, tagged with a check id. This block arbitrates round-robin, decodes the MAC against the local ToR identity and the currently connected optical ToR, and returns {outport, seek_flag, check_id} to the requesting port only.
- Sits beside the RX stages, between their check request outputs and their result inputs.

Parameters:
- P_PORT_NUM, 4, number of RX requesters (2..8).
- P_MAC_HEAD, 32'h8D_BC_5C_4A, required value of dst_mac[47:16].
- P_MY_TOR_ID, 3'd0, this ToR's index (dst_mac[15:8]).
- P_DOWN_PORTS, 2, number of valid local port indices; legal port bytes are 1..P_DOWN_PORTS.
- P_UPLINK_PORT, 3'd7, outport code for the optical uplink.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_check_mac  in  48*P_PORT_NUM  per-port destination MAC; port p at [48p+47:48p].
- i_check_id  in  4*P_PORT_NUM  per-port request tag.
- i_check_valid  in  P_PORT_NUM  one-cycle request strobe per port.
- i_cur_connect_tor  in  3  ToR currently reachable through the uplink.
- i_connect_valid  in  1  uplink slot active.
- o_outport  out  3  lookup result port.
- o_seek_flag  out  2  0 = local, 1 = uplink direct, 2 = buffer (DDR), 3 = drop.
- o_check_id  out  4  echoed tag.
- o_result_valid  out  P_PORT_NUM  one-hot, one-cycle result strobe to the requesting port.
- o_req_overrun  out  P_PORT_NUM  one-cycle pulse when a request overwrote an unserved one.

Behaviour:
- Reset is synchronous, active-high, single clock domain.
- Reset values: all outputs 0. Pending flags, pipeline valids and the RR pointer are also 0.
- Request capture, per port p:
  - i_check_valid[p] at edge k stores mac/id into slot p and sets pending[p].
  - If pending[p] is already set and not granted in the same cycle: the new request overwrites the slot and o_req_overrun[p] pulses at edge k+1.
- Arbitration:
  - Combinational round-robin over pending, starting at rr_ptr.
  - Grant at edge k+1 loads stage-1 (mac, id, port index) and clears pending[g].
  - rr_ptr becomes g+1, wrapping at P_PORT_NUM-1 back to 0.
  - At most one grant per cycle.
  - A new valid on the granted port in the same cycle: set wins and the new request is queued; no overrun.
- Decode (stage-1 to output register at edge k+2). Rules apply in priority order:
  - dst[47:16] != P_MAC_HEAD -> flag 3, outport 0.
  - dst[15:11] != 0 -> flag 3, outport 0.
  - tor == P_MY_TOR_ID:
    - port byte in 1..P_DOWN_PORTS -> flag 0, outport = port-1.
    - otherwise -> flag 3, outport 0.
  - i_connect_valid and tor == i_cur_connect_tor (sampled at the decode edge) -> flag 1, outport = P_UPLINK_PORT.
  - Otherwise -> flag 2, outport = tor.
- Outputs:
  - o_result_valid[g] is high for exactly one cycle after edge k+2.
  - outport, flag and id are held until the next result.
- Latency: uncontended, the result is seen 2 cycles after the request cycle. Worst case is 2 + (P_PORT_NUM-1) cycles.
- Throughput: one result per cycle, fully pipelined.
- Reset mid-operation: in-flight and pending requests are discarded and no result is emitted.

Decomposition:
- Package ten_eth_pkg holds:
  - seek-flag constants SEEK_LOCAL=0, SEEK_UPLINK=1, SEEK_BUFFER=2, SEEK_DROP=3;
  - MAC field positions;
  - P_MAC_HEAD default.
- One natural sub-module: rr_arbiter (P_PORT_NUM request vector in, one-hot grant and index out, pointer register inside).

Test Plan:
- Local hit: P_MY_TOR_ID=0, port0 requests MAC 8DBC5C4A_00_02 with id 5 -> 2 cycles later o_result_valid=0001, flag 0, outport 1, id 5.
- Uplink vs buffer: cur_connect_tor=3 with connect_valid=1, MAC ..._03_01 -> flag 1, outport 7. With connect_valid=0 -> flag 2, outport 3.
- Drop cases: head 8DBC5C4B, or tor byte 0x09, or local port byte 0 / 3 -> flag 3, outport 0.
- Contention: all 4 ports request in the same cycle with ids 1..4 -> results on 4 consecutive cycles, one-hot 0001, 0010, 0100, 1000. The next simultaneous burst starts at port 0 after the pointer wraps.
- Overrun: port1 requests on two cycles while port0 holds the grant. The second request arrives before port1 is granted -> o_req_overrun[1] pulses and only the second id is returned. Port1 requesting in its own grant cycle -> no overrun, two results.
- Reset mid-flight: i_rst asserted one cycle after a request -> no o_result_valid, and all outputs are 0 on the following cycle.
